// File: rtl/ram_capture_writer.sv
// ram_capture_writer: splits 16-bit ADC samples into two byte writes on the sample RAM write port.
// Revision 1.0 - initial release.
`default_nettype none

module ram_capture_writer #(
  parameter int ADDR_W = 9
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              arm_i,
  input  logic              trig_i,
  input  logic [15:0]       sample_i,
  input  logic              sample_valid_i,
  output logic              ready_o,
  output logic [ADDR_W-1:0] waddr_o,
  output logic [7:0]        wdata_o,
  output logic              we_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              overrun_o,
  output logic [ADDR_W-1:0] count_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARMED  = 3'd1,
    S_CAP_LO = 3'd2,
    S_CAP_HI = 3'd3,
    S_FULL   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   ptr_q, ptr_d;
  logic [7:0]        hold_q, hold_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic              overrun_q, overrun_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      hold_q    <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    we_d      = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;

    if (arm_i) begin
      // Re-arm wins over everything, including a pending high byte.
      state_d   = S_ARMED;
      ptr_d     = '0;
      count_d   = '0;
      overrun_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_IDLE;
        end
        S_ARMED: begin
          if (trig_i) begin
            state_d = S_CAP_LO;
          end
        end
        S_CAP_LO: begin
          if (sample_valid_i) begin
            we_d    = 1'b1;
            waddr_d = ptr_q[ADDR_W-1:0];
            wdata_d = sample_i[7:0];
            hold_d  = sample_i[15:8];
            ptr_d   = ptr_q + {{ADDR_W{1'b0}}, 1'b1};
            state_d = S_CAP_HI;
          end
        end
        S_CAP_HI: begin
          we_d    = 1'b1;
          waddr_d = ptr_q[ADDR_W-1:0];
          wdata_d = hold_q;
          ptr_d   = ptr_q + {{ADDR_W{1'b0}}, 1'b1};
          count_d = count_q + {{(ADDR_W-1){1'b0}}, 1'b1};
          if (sample_valid_i) begin
            overrun_d = 1'b1;
          end
          // Carry into the extra pointer bit means the last address was just written.
          state_d = ptr_d[ADDR_W] ? S_FULL : S_CAP_LO;
        end
        S_FULL: begin
          state_d = S_FULL;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    ready_d = (state_d == S_CAP_LO);
    // BUSY stays up through the final high-byte write; DONE follows one cycle later.
    busy_d  = (state_d == S_ARMED) || (state_d == S_CAP_LO) ||
              (state_d == S_CAP_HI) || we_d;
    done_d  = (state_q == S_FULL) && (state_d == S_FULL);
  end

  assign ready_o   = ready_q;
  assign waddr_o   = waddr_q;
  assign wdata_o   = wdata_q;
  assign we_o      = we_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign overrun_o = overrun_q;
  assign count_o   = count_q;

endmodule

`default_nettype wire

// File: tb/tb_ram_capture_writer.sv
// tb_ram_capture_writer: directed bench for ram_capture_writer with a falling-edge RAM model.
// Revision 1.0 - initial release.
`default_nettype none

module tb_ram_capture_writer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       arm = 1'b0;
  logic       trig = 1'b0;
  logic [15:0] sample = 16'h0000;
  logic       sample_valid = 1'b0;
  logic       ready;
  logic [8:0] waddr;
  logic [7:0] wdata;
  logic       we;
  logic       busy;
  logic       done;
  logic       overrun;
  logic [8:0] count;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] ram [0:511];

  ram_capture_writer #(.ADDR_W(9)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .arm_i          (arm),
    .trig_i         (trig),
    .sample_i       (sample),
    .sample_valid_i (sample_valid),
    .ready_o        (ready),
    .waddr_o        (waddr),
    .wdata_o        (wdata),
    .we_o           (we),
    .busy_o         (busy),
    .done_o         (done),
    .overrun_o      (overrun),
    .count_o        (count)
  );

  always #5 clk = ~clk;

  // RAM commits on the falling edge, half a cycle after the outputs update.
  always @(negedge clk) begin
    if (we) ram[waddr] <= wdata;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one sample at READY, then leave valid low for the high-byte cycle.
  task automatic feed(input logic [15:0] s);
    chk("feed_ready", {31'd0, ready}, 32'd1);
    sample       = s;
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    step();
  endtask

  initial begin
    int stray;
    int bad;

    // Reset values
    step();
    step();
    chk("rst_we", {31'd0, we}, 32'd0);
    chk("rst_waddr", {23'd0, waddr}, 32'd0);
    chk("rst_wdata", {24'd0, wdata}, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    chk("rst_count", {23'd0, count}, 32'd0);

    // IDLE ignores TRIG and SAMPLE_VALID
    rst = 1'b0;
    trig = 1'b1;
    sample_valid = 1'b1;
    step();
    trig = 1'b0;
    sample_valid = 1'b0;
    chk("idle_ready", {31'd0, ready}, 32'd0);
    chk("idle_we", {31'd0, we}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // ARM
    arm = 1'b1;
    step();
    arm = 1'b0;
    chk("arm_busy", {31'd0, busy}, 32'd1);
    chk("arm_done", {31'd0, done}, 32'd0);
    chk("arm_ready", {31'd0, ready}, 32'd0);

    // SAMPLE_VALID while ARMED is ignored
    sample = 16'hDEAD;
    sample_valid = 1'b1;
    step();
    step();
    sample_valid = 1'b0;
    chk("armed_we", {31'd0, we}, 32'd0);
    chk("armed_overrun", {31'd0, overrun}, 32'd0);
    chk("armed_ready", {31'd0, ready}, 32'd0);

    // TRIG
    trig = 1'b1;
    step();
    trig = 1'b0;
    chk("trig_ready", {31'd0, ready}, 32'd1);
    chk("trig_busy", {31'd0, busy}, 32'd1);

    // Back-to-back samples 0x1234, 0xABCD
    sample = 16'h1234;
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    chk("s0_lo_we", {31'd0, we}, 32'd1);
    chk("s0_lo_addr", {23'd0, waddr}, 32'd0);
    chk("s0_lo_data", {24'd0, wdata}, 32'h34);
    chk("s0_lo_ready", {31'd0, ready}, 32'd0);
    step();
    chk("s0_hi_we", {31'd0, we}, 32'd1);
    chk("s0_hi_addr", {23'd0, waddr}, 32'd1);
    chk("s0_hi_data", {24'd0, wdata}, 32'h12);
    chk("s0_hi_count", {23'd0, count}, 32'd1);
    chk("s0_hi_ready", {31'd0, ready}, 32'd1);
    sample = 16'hABCD;
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    chk("s1_lo_addr", {23'd0, waddr}, 32'd2);
    chk("s1_lo_data", {24'd0, wdata}, 32'hCD);
    step();
    chk("s1_hi_addr", {23'd0, waddr}, 32'd3);
    chk("s1_hi_data", {24'd0, wdata}, 32'hAB);
    chk("s1_hi_count", {23'd0, count}, 32'd2);
    step();
    chk("gap_we", {31'd0, we}, 32'd0);
    chk("ram_0_3", {ram[3], ram[2], ram[1], ram[0]}, 32'hABCD1234);

    // SAMPLE_VALID held high: every second sample dropped
    sample_valid = 1'b1;
    sample = 16'hA1B2;
    step();
    chk("ov_a_addr", {23'd0, waddr}, 32'd4);
    chk("ov_a_data", {24'd0, wdata}, 32'hB2);
    sample = 16'hEEEE;
    step();
    chk("ov_b_overrun", {31'd0, overrun}, 32'd1);
    chk("ov_b_data", {24'd0, wdata}, 32'hA1);
    sample = 16'hC3D4;
    step();
    chk("ov_c_addr", {23'd0, waddr}, 32'd6);
    chk("ov_c_data", {24'd0, wdata}, 32'hD4);
    sample = 16'hFFFF;
    step();
    chk("ov_d_addr", {23'd0, waddr}, 32'd7);
    chk("ov_d_data", {24'd0, wdata}, 32'hC3);
    chk("ov_d_count", {23'd0, count}, 32'd4);
    sample_valid = 1'b0;
    step();
    chk("ov_gap_we", {31'd0, we}, 32'd0);
    chk("ram_4_7", {ram[7], ram[6], ram[5], ram[4]}, 32'hC3D4A1B2);

    // ARM during CAP_HI of sample 10
    for (int i = 4; i < 10; i++) feed(16'(i));
    sample = 16'h0A0A;
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    chk("s10_addr", {23'd0, waddr}, 32'd20);
    arm = 1'b1;
    step();
    arm = 1'b0;
    chk("rearm_we", {31'd0, we}, 32'd0);
    chk("rearm_count", {23'd0, count}, 32'd0);
    chk("rearm_overrun", {31'd0, overrun}, 32'd0);
    chk("rearm_busy", {31'd0, busy}, 32'd1);
    trig = 1'b1;
    step();
    trig = 1'b0;
    sample = 16'h5566;
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    chk("rearm_first_addr", {23'd0, waddr}, 32'd0);
    chk("rearm_first_data", {24'd0, wdata}, 32'h66);
    step();
    chk("rearm_hi_addr", {23'd0, waddr}, 32'd1);

    // RST at ptr=100
    for (int i = 1; i < 50; i++) feed(16'(i));
    chk("pre_rst_count", {23'd0, count}, 32'd50);
    rst = 1'b1;
    sample = 16'hFFFF;
    sample_valid = 1'b1;
    step();
    rst = 1'b0;
    sample_valid = 1'b0;
    chk("mrst_we", {31'd0, we}, 32'd0);
    chk("mrst_waddr", {23'd0, waddr}, 32'd0);
    chk("mrst_wdata", {24'd0, wdata}, 32'd0);
    chk("mrst_ready", {31'd0, ready}, 32'd0);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_count", {23'd0, count}, 32'd0);
    step();
    chk("mrst_idle_we", {31'd0, we}, 32'd0);
    chk("mrst_idle_busy", {31'd0, busy}, 32'd0);

    // Full capture of 256 samples
    arm = 1'b1;
    step();
    arm = 1'b0;
    trig = 1'b1;
    step();
    trig = 1'b0;
    for (int i = 0; i < 255; i++) feed(16'(i * 16'h0101));
    chk("last_ready", {31'd0, ready}, 32'd1);
    sample = 16'hFFFF;
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    chk("last_lo_addr", {23'd0, waddr}, 32'd510);
    step();
    chk("last_hi_we", {31'd0, we}, 32'd1);
    chk("last_hi_addr", {23'd0, waddr}, 32'd511);
    chk("last_hi_data", {24'd0, wdata}, 32'hFF);
    chk("last_hi_busy", {31'd0, busy}, 32'd1);
    chk("last_hi_done", {31'd0, done}, 32'd0);
    chk("last_hi_count", {23'd0, count}, 32'd256);
    step();
    chk("full_done", {31'd0, done}, 32'd1);
    chk("full_busy", {31'd0, busy}, 32'd0);
    chk("full_we", {31'd0, we}, 32'd0);
    chk("full_count", {23'd0, count}, 32'd256);
    chk("full_ready", {31'd0, ready}, 32'd0);
    stray = 0;
    sample_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (we) stray++;
    end
    sample_valid = 1'b0;
    chk("full_no_write", 32'(stray), 32'd0);
    chk("full_done_sticky", {31'd0, done}, 32'd1);
    bad = 0;
    for (int i = 0; i < 512; i++) begin
      if (ram[i] !== 8'(i >> 1)) bad++;
    end
    chk("full_ram_bad", 32'(bad), 32'd0);

    // ARM clears DONE
    arm = 1'b1;
    step();
    arm = 1'b0;
    chk("arm2_done", {31'd0, done}, 32'd0);
    chk("arm2_busy", {31'd0, busy}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ram_capture_writer.md
# ram_capture_writer

Capture front end that fills the 512x8 dual-port sample RAM with 16-bit ADC conversion results. Each accepted sample is split into two byte writes, low byte at even address, high byte at the next odd address. The block drives the RAM write port (WADDR/WDATA/WE) and signals completion to the readout logic, which drains the RAM through the read port. One arm/trigger cycle captures exactly 256 samples (512 bytes) linearly from address 0.

## Interface
- ADDR_W, 9, RAM address width; depth is 2^ADDR_W bytes.
- Clock and reset: one clock, CLK. Reset RST is synchronous and active-high.
- CLK  in  1  system clock; also drives the RAM WCLK.
- RST  in  1  synchronous active-high reset.
- ARM  in  1  start or restart a capture; single-cycle pulse.
- TRIG  in  1  trigger qualifier; sampled only while armed.
- SAMPLE  in  16  ADC result; valid when SAMPLE_VALID=1.
- SAMPLE_VALID  in  1  SAMPLE is presented this cycle.
- READY  out  1  block accepts a sample this cycle.
- WADDR  out  ADDR_W  RAM write address.
- WDATA  out  8  RAM write data.
- WE  out  1  RAM write enable.
- BUSY  out  1  armed or capturing.
- DONE  out  1  RAM full with a complete capture; sticky until ARM.
- OVERRUN  out  1  a sample was dropped; sticky until ARM.
- COUNT  out  ADDR_W  number of complete samples written, 0..256.

## Operation
- State machine states:
  - IDLE: after reset.
  - ARMED: BUSY=1. TRIG=1 moves to CAP_LO. SAMPLE_VALID is ignored and does not flag OVERRUN.
  - CAP_LO: READY=1. When SAMPLE_VALID=1:
    - drive WE=1, WADDR=ptr, WDATA=SAMPLE[7:0];
    - latch SAMPLE[15:8] into a hold register;
    - ptr++, go to CAP_HI.
  - CAP_HI: READY=0. Drive WE=1, WADDR=ptr, WDATA=hold; ptr++; COUNT++.
    - If ptr was 2^ADDR_W-1, go to FULL; otherwise go to CAP_LO.
  - FULL: DONE=1, BUSY=0.
- WE is 0 in every cycle that is not a byte write.
- SAMPLE_VALID=1 in CAP_HI sets OVERRUN; that sample is dropped and no write occurs.
- ARM in any state:
  - ptr=0, COUNT=0, DONE=0, OVERRUN=0; go to ARMED.
  - ARM has priority over SAMPLE_VALID and TRIG in the same cycle.
  - ARM in CAP_HI discards the pending high byte, with WE=0 next cycle. Bytes already written stay in the RAM and are overwritten by the new capture.
- ptr is ADDR_W+1 bits internally; WADDR = ptr[ADDR_W-1:0]. Addresses never wrap within a capture.
- Reset values: state IDLE, ptr=0, hold=0, and all outputs 0 (WADDR=0, WDATA=0, WE=0, READY=0, BUSY=0, DONE=0, OVERRUN=0, COUNT=0).

## Timing
- All outputs are registered on the rising edge of CLK.
- The RAM samples WADDR/WDATA/WE on the falling edge of the same clock, so each write commits half a cycle after the outputs update. Setup is half a period.
- Sample accepted at edge k:
  - low-byte write outputs are valid for cycle k+1;
  - high-byte write outputs are valid for cycle k+2;
  - READY returns at k+2 in CAP_LO.
- Maximum accept rate is one sample per 2 cycles. Upstream must honour READY.
- TRIG seen at edge k in ARMED gives READY=1 from cycle k+1.
- Last high-byte write (WADDR=511) is driven in cycle n. In cycle n+1: DONE=1, BUSY=0, WE=0, COUNT=256.
- ARM at edge k gives BUSY=1 and DONE=0 in cycle k+1.
- RST asserted mid-capture returns the block to reset values on the next edge. No further writes occur.

## Test plan
- Reset, then ARM and TRIG, then samples 0x1234 and 0xABCD back-to-back at READY -> writes (0,0x34), (1,0x12), (2,0xCD), (3,0xAB) on consecutive valid cycles; COUNT=2.
- Full capture of 256 samples with value i*0x0101 -> RAM[2i]=RAM[2i+1]=i[7:0]. DONE rises one cycle after the addr 511 write; BUSY=0; COUNT=256; no write to addr 0 afterward.
- SAMPLE_VALID held high every cycle -> every second sample is dropped, OVERRUN=1, and only even-cycle samples are written.
- ARM during CAP_HI at sample 10 -> WE=0 next cycle, COUNT=0, OVERRUN=0. The next capture starts at WADDR=0 after TRIG.
- SAMPLE_VALID pulses in ARMED before TRIG -> no writes and OVERRUN stays 0. After TRIG, the first write is at address 0.
- RST asserted during capture at ptr=100 -> next cycle all outputs are 0 and state is IDLE. ARM restarts from address 0.
